bank_burst: RTL and testbench
=============================

BANK_BURST -- requirements
Module: bank_burst

Interface
REQ-001 Parameter DEVICE_WIDTH, 4, dq bits per beat.
REQ-002 Parameter COLWIDTH, 10, column address bits.
REQ-003 Parameter ROWWIDTH, 5, row address bits.
REQ-004 Parameter BL, 8, burst length in beats.
REQ-005 Parameter tRCD, 3, ACT-to-RD/WR delay in cycles.
REQ-006 Parameter tRP, 3, PRE-to-IDLE delay in cycles.
REQ-007 Parameter tCL, 4, RD-to-first-read-beat latency in cycles.
REQ-008 Parameter tCWL, 3, WR-to-first-write-beat latency in cycles.
REQ-009 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-010 clk  in  1  rising-edge clock.
REQ-011 reset_n  in  1  asynchronous active-low reset.
REQ-012 cmd  in  3  command, a bank_pkg cmd_t value: NOP, ACT, RD, WR, PRE.
REQ-013 row  in  ROWWIDTH  row address, sampled with ACT.
REQ-014 column  in  COLWIDTH  burst start column, sampled with RD/WR.
REQ-015 dqin  in  DEVICE_WIDTH  write beat data.
REQ-016 dqout  out  DEVICE_WIDTH  read beat data, 0 when dq_valid low.
REQ-017 dq_valid  out  1  high during each read beat.
REQ-018 state  out  2  bank_pkg state_t: IDLE, ACTIVATING, ACTIVE, PRECHARGING.
REQ-019 open_row  out  ROWWIDTH  latched row; meaningful in ACTIVE.
REQ-020 burst_busy  out  1  high from RD/WR acceptance through the last beat.
REQ-021 cmd_err  out  1  one-cycle pulse on a rejected command.

Function
REQ-022 Storage SHALL be 2^ROWWIDTH x 2^COLWIDTH words of DEVICE_WIDTH bits.
REQ-023 ACT in IDLE at edge N: latch row; ACTIVATING; ACTIVE from edge N+tRCD; first legal RD/WR at edge N+tRCD.
REQ-024 PRE in ACTIVE with burst_busy low at edge N: PRECHARGING; IDLE from edge N+tRP.
REQ-025 PRE in IDLE SHALL be a legal no-op without cmd_err.
REQ-026 RD accepted at edge N: dqout/dq_valid present beat k during the cycle after edge N+tCL+k-1, k=0..BL-1.
REQ-027 WR accepted at edge N: dqin sampled at edge N+tCWL+k, k=0..BL-1, written to open_row.
REQ-028 Beat k column SHALL be {column[COLWIDTH-1:log2 BL], (column[log2 BL-1:0]+k) mod BL} (aligned-block wrap).
REQ-029 burst_busy SHALL rise the cycle after acceptance and fall the cycle after the last beat edge.
REQ-030 Rejected commands: ACT outside IDLE; RD/WR outside ACTIVE or with burst_busy high; PRE in ACTIVATING, PRECHARGING, or with burst_busy high.
REQ-031 A rejected command SHALL pulse cmd_err for exactly one cycle and change no state, address, or storage.
REQ-032 Undefined cmd encodings SHALL behave as NOP.
REQ-033 Parameters SHALL satisfy tRCD, tRP, tCL, tCWL >= 1 and BL a power of two <= 2^COLWIDTH; violation is an elaboration error.

Reset
REQ-034 While reset_n is low: state=IDLE, open_row=0, dqout=0, dq_valid=0, burst_busy=0, cmd_err=0; all counters cleared.
REQ-035 Reset mid-burst SHALL abort the burst; written beats persist; storage is never reset.

Structure
REQ-036 Package bank_pkg SHALL hold cmd_t, state_t, and a parameter-check function.
REQ-037 Sub-module bank_burst_seq SHALL hold the latency counter, beat index, and wrapped-column generation.

Verification
REQ-038 Reset, ACT row 1, WR col 0 at edge tRCD with dqin 3,7,1,0,9,F,2,5 -> RD col 0 returns same 8 beats, first tCL cycles after RD.
REQ-039 WR col 6 with data 0..7 -> RD col 0 returns 2,3,4,5,6,7,0,1 (wrap in block 0..7).
REQ-040 RD at edge N+tRCD-1 after ACT, then RD during active burst -> cmd_err pulses each time, no dq_valid from either.
REQ-041 PRE then ACT at edge tRP-1 -> cmd_err; ACT at edge tRP -> accepted, state ACTIVATING.
REQ-042 reset_n low after beat 3 of an 8-beat WR, reactivate, RD -> beats 0-2 hold written data, beats 3-7 hold prior contents.
REQ-043 Row isolation: WR row 1 then PRE, ACT row 2 -> RD row 2 does not return row 1 data; open_row equals 2.

Source files
------------

// File: rtl/bank_pkg.sv
// bank_pkg: command, state and sequencer types
// plus the elaboration-time parameter check.
package bank_pkg;

  typedef enum logic [2:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACTIVATING  = 2'd1,
    ACTIVE      = 2'd2,
    PRECHARGING = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SQ_IDLE = 2'd0,
    SQ_WAIT = 2'd1,
    SQ_DATA = 2'd2
  } seq_phase_t;

  // width of the timing down-counters
  localparam int TW = 8;

  function automatic bit params_ok(
    input int trcd,
    input int trp,
    input int tcl,
    input int tcwl,
    input int bl,
    input int colw
  );
    bit ok;
    ok = (trcd >= 1) && (trp >= 1);
    ok = ok && (tcl >= 1) && (tcwl >= 1);
    ok = ok && (trcd <= (1 << TW));
    ok = ok && (trp <= (1 << TW));
    ok = ok && (tcl <= (1 << TW));
    ok = ok && (tcwl <= (1 << TW));
    ok = ok && (bl >= 1);
    ok = ok && ((bl & (bl - 1)) == 0);
    ok = ok && (colw >= 1) && (colw < 31);
    ok = ok && (bl <= (1 << colw));
    return ok;
  endfunction

endpackage

// File: rtl/bank_burst_seq.sv
// bank_burst_seq: burst latency countdown, beat
// index and aligned-block wrapped column.
module bank_burst_seq
  import bank_pkg::*;
#(
  parameter int COLWIDTH = 10,
  parameter int BL       = 8,
  parameter int tCL      = 4,
  parameter int tCWL     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                start_rd,
  input  logic [COLWIDTH-1:0] start_col,
  output logic                busy,
  output logic                beat_valid,
  output logic                beat_rd,
  output logic [COLWIDTH-1:0] beat_col
);

  localparam logic [COLWIDTH-1:0] MASK =
    COLWIDTH'(BL - 1);
  localparam logic [TW-1:0] RD_LAT = TW'(tCL - 1);
  localparam logic [TW-1:0] WR_LAT = TW'(tCWL - 1);

  seq_phase_t          phase_q, phase_d;
  logic [TW-1:0]       lat_q, lat_d;
  logic [TW-1:0]       lat_load;
  logic [COLWIDTH-1:0] beat_q, beat_d;
  logic [COLWIDTH-1:0] col_q, col_d;
  logic                rd_q, rd_d;

  // Phase and burst registers; reset aborts a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= SQ_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      col_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      col_q   <= col_d;
      rd_q    <= rd_d;
    end
  end

  // Wait out the latency, then step one beat/cycle.
  always_comb begin
    lat_load = start_rd ? RD_LAT : WR_LAT;
    phase_d  = phase_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    col_d    = col_q;
    rd_d     = rd_q;
    unique case (phase_q)
      SQ_IDLE: begin
        if (start) begin
          rd_d   = start_rd;
          col_d  = start_col;
          beat_d = '0;
          if (lat_load == '0) begin
            phase_d = SQ_DATA;
          end else begin
            phase_d = SQ_WAIT;
            lat_d   = lat_load - TW'(1);
          end
        end
      end
      SQ_WAIT: begin
        if (lat_q == '0) begin
          phase_d = SQ_DATA;
        end else begin
          lat_d = lat_q - TW'(1);
        end
      end
      SQ_DATA: begin
        beat_d = beat_q + COLWIDTH'(1);
        if (beat_q == MASK) begin
          phase_d = SQ_IDLE;
        end
      end
      default: phase_d = SQ_IDLE;
    endcase
  end

  // Beat strobes and the wrapped beat column.
  always_comb begin
    busy       = (phase_q != SQ_IDLE);
    beat_valid = (phase_q == SQ_DATA);
    beat_rd    = rd_q;
    beat_col   = (col_q & ~MASK)
               | ((col_q + beat_q) & MASK);
  end

endmodule

// File: rtl/bank_burst.sv
// bank_burst: single-bank row open/close FSM with
// fixed-length wrapped read and write bursts.
module bank_burst
  import bank_pkg::*;
#(
  parameter int DEVICE_WIDTH = 4,
  parameter int COLWIDTH     = 10,
  parameter int ROWWIDTH     = 5,
  parameter int BL           = 8,
  parameter int tRCD         = 3,
  parameter int tRP          = 3,
  parameter int tCL          = 4,
  parameter int tCWL         = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              cmd,
  input  logic [ROWWIDTH-1:0]     row,
  input  logic [COLWIDTH-1:0]     column,
  input  logic [DEVICE_WIDTH-1:0] dqin,
  output logic [DEVICE_WIDTH-1:0] dqout,
  output logic                    dq_valid,
  output logic [1:0]              state,
  output logic [ROWWIDTH-1:0]     open_row,
  output logic                    burst_busy,
  output logic                    cmd_err
);

  if (!params_ok(tRCD, tRP, tCL, tCWL,
                 BL, COLWIDTH)) begin : g_bad_params
    $error("bank_burst: illegal parameters");
  end

  localparam int AW    = ROWWIDTH + COLWIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [TW-1:0] RCD_LOAD = TW'(tRCD - 1);
  localparam logic [TW-1:0] RP_LOAD  = TW'(tRP - 1);

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [ROWWIDTH-1:0] open_row_q, open_row_d;
  logic                cmd_err_q, cmd_err_d;

  logic is_act, is_rd, is_wr, is_pre;
  logic act_ok, idle_ok;
  logic acc_act, acc_rw, acc_pre, reject;

  logic                seq_busy;
  logic                beat_valid;
  logic                beat_rd;
  logic [COLWIDTH-1:0] beat_col;
  logic [AW-1:0]       beat_addr;

  logic [DEVICE_WIDTH-1:0] mem [DEPTH];

  bank_burst_seq #(
    .COLWIDTH (COLWIDTH),
    .BL       (BL),
    .tCL      (tCL),
    .tCWL     (tCWL)
  ) u_seq (
    .clk        (clk),
    .rst_n      (reset_n),
    .start      (acc_rw),
    .start_rd   (is_rd),
    .start_col  (column),
    .busy       (seq_busy),
    .beat_valid (beat_valid),
    .beat_rd    (beat_rd),
    .beat_col   (beat_col)
  );

  // Bank state, timing counter, row and error flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      open_row_q <= '0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      open_row_q <= open_row_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // Legality: an expired timer counts as the next state.
  always_comb begin
    is_act  = (cmd == ACT);
    is_rd   = (cmd == RD);
    is_wr   = (cmd == WR);
    is_pre  = (cmd == PRE);
    act_ok  = (state_q == ACTIVE)
           || ((state_q == ACTIVATING)
               && (timer_q == '0));
    idle_ok = (state_q == IDLE)
           || ((state_q == PRECHARGING)
               && (timer_q == '0));
    acc_act = 1'b0;
    acc_rw  = 1'b0;
    acc_pre = 1'b0;
    reject  = 1'b0;
    unique case (1'b1)
      is_act: begin
        if (idle_ok) acc_act = 1'b1;
        else         reject  = 1'b1;
      end
      is_rd, is_wr: begin
        if (act_ok && !seq_busy) acc_rw = 1'b1;
        else                     reject = 1'b1;
      end
      is_pre: begin
        if (act_ok && !seq_busy) acc_pre = 1'b1;
        else if (!idle_ok)       reject  = 1'b1;
      end
      default: ;
    endcase
  end

  // Next bank state, timer reload and row latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    open_row_d = open_row_q;
    cmd_err_d  = reject;
    if (acc_act) begin
      state_d    = ACTIVATING;
      timer_d    = RCD_LOAD;
      open_row_d = row;
    end else if (acc_pre) begin
      state_d = PRECHARGING;
      timer_d = RP_LOAD;
    end else begin
      unique case (state_q)
        ACTIVATING: begin
          if (timer_q == '0) state_d = ACTIVE;
          else timer_d = timer_q - TW'(1);
        end
        PRECHARGING: begin
          if (timer_q == '0) state_d = IDLE;
          else timer_d = timer_q - TW'(1);
        end
        IDLE, ACTIVE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Write beats land at the end of their beat cycle.
  always_ff @(posedge clk) begin
    if (beat_valid && !beat_rd) begin
      mem[beat_addr] <= dqin;
    end
  end

  // Outputs; read data is forced to 0 off-beat.
  always_comb begin
    beat_addr  = {open_row_q, beat_col};
    state      = state_q;
    open_row   = open_row_q;
    cmd_err    = cmd_err_q;
    burst_busy = seq_busy;
    dq_valid   = beat_valid && beat_rd;
    dqout      = dq_valid ? mem[beat_addr] : '0;
  end

endmodule

// File: tb/tb_bank_burst.sv
// tb_bank_burst: timestamp-based bank model with
// per-cycle compare plus literal burst checks.
module tb_bank_burst;
  import bank_pkg::*;

  localparam int DW   = 4;
  localparam int CW   = 10;
  localparam int RW   = 5;
  localparam int BL   = 8;
  localparam int TRCD = 3;
  localparam int TRP  = 3;
  localparam int TCL  = 4;
  localparam int TCWL = 3;
  localparam int NC   = 1024;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    cmd;
  logic [RW-1:0] row;
  logic [CW-1:0] column;
  logic [DW-1:0] dqin;
  logic [DW-1:0] dqout;
  logic          dq_valid;
  logic [1:0]    state;
  logic [RW-1:0] open_row;
  logic          burst_busy;
  logic          cmd_err;

  bank_burst #(
    .DEVICE_WIDTH (DW),
    .COLWIDTH     (CW),
    .ROWWIDTH     (RW),
    .BL           (BL),
    .tRCD         (TRCD),
    .tRP          (TRP),
    .tCL          (TCL),
    .tCWL         (TCWL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd        (cmd),
    .row        (row),
    .column     (column),
    .dqin       (dqin),
    .dqout      (dqout),
    .dq_valid   (dq_valid),
    .state      (state),
    .open_row   (open_row),
    .burst_busy (burst_busy),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  bit m_open;
  int m_row;
  int m_ready_at;
  int busy_last;
  int mem_m [int];

  bit e_v [NC];
  bit e_dk [NC];
  int e_d [NC];
  int e_state [NC];
  bit e_busy [NC];
  bit e_err [NC];
  bit e_rowchk [NC];
  int e_row [NC];
  bit w_v [NC];
  int w_a [NC];
  int w_d [NC];

  int wr_buf [BL];
  int lit [BL];
  int rq [$];
  int err_cnt;
  int first_v;
  int rd_n;

  task automatic chk(input string nm,
                     input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic int col_of(input int col,
                                input int k);
    return (col / BL) * BL + ((col % BL) + k) % BL;
  endfunction

  task automatic rst_exp(input int i);
    e_state[i]  = int'(IDLE);
    e_busy[i]   = 0;
    e_err[i]    = 0;
    e_v[i]      = 0;
    e_rowchk[i] = 1;
    e_row[i]    = 0;
  endtask

  task automatic model_reset();
    m_open     = 0;
    m_row      = 0;
    m_ready_at = 0;
    busy_last  = -100;
    for (int i = cyc; i < NC; i++) begin
      e_v[i] = 0;
      w_v[i] = 0;
    end
  endtask

  task automatic model_cmd(input int n,
                           input logic [2:0] c,
                           input int r,
                           input int col);
    bit busy;
    bit rej;
    int lat;
    int a;
    int idx;
    busy = (n <= busy_last + 1);
    rej  = 0;
    case (c)
      ACT: begin
        if (!m_open && n >= m_ready_at) begin
          m_open     = 1;
          m_row      = r;
          m_ready_at = n + TRCD;
        end else rej = 1;
      end
      RD, WR: begin
        if (m_open && n >= m_ready_at && !busy) begin
          lat       = (c == RD) ? TCL : TCWL;
          busy_last = n + lat + BL - 2;
          for (int k = 0; k < BL; k++) begin
            a = m_row * (1 << CW) + col_of(col, k);
            if (c == RD) begin
              idx       = n + TCL - 1 + k;
              e_v[idx]  = 1;
              e_dk[idx] = !mem_m.exists(a);
              e_d[idx]  = 0;
              if (mem_m.exists(a)) e_d[idx] = mem_m[a];
            end else begin
              idx      = n + TCWL + k;
              w_v[idx] = 1;
              w_a[idx] = a;
              w_d[idx] = wr_buf[k];
            end
          end
        end else rej = 1;
      end
      PRE: begin
        if (!m_open) begin
          if (n < m_ready_at) rej = 1;
        end else if (n >= m_ready_at && !busy) begin
          m_open     = 0;
          m_ready_at = n + TRP;
        end else rej = 1;
      end
      default: ;
    endcase
    e_err[n]  = rej;
    e_busy[n] = (n <= busy_last);
    if (m_open)
      e_state[n] = (n >= m_ready_at) ?
                   int'(ACTIVE) : int'(ACTIVATING);
    else
      e_state[n] = (n >= m_ready_at) ?
                   int'(IDLE) : int'(PRECHARGING);
    e_rowchk[n] = (e_state[n] == int'(ACTIVE));
    e_row[n]    = m_row;
  endtask

  task automatic step(input logic [2:0] c,
                      input int r = 0,
                      input int col = 0,
                      input bit rst = 0);
    int n;
    n       = cyc + 1;
    reset_n = !rst;
    cmd     = c;
    row     = RW'(r);
    column  = CW'(col);
    if (rst) begin
      model_reset();
      rst_exp(cyc);
      rst_exp(n);
      dqin = DW'($urandom);
    end else begin
      if (w_v[n]) begin
        dqin           = DW'(w_d[n]);
        mem_m[w_a[n]]  = w_d[n];
      end else begin
        dqin = DW'($urandom);
      end
      model_cmd(n, c, r, col);
    end
    chk_en = 1;
    @(posedge clk);
    cyc = n;
    #1;
  endtask

  task automatic nop(input int k);
    repeat (k) step(NOP);
  endtask

  task automatic chk_burst(input string nm);
    chk({nm, "_len"}, rq.size(), BL);
    for (int k = 0; k < BL; k++) begin
      chk(nm, (k < rq.size()) ? rq[k] : -1, lit[k]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(state), e_state[cyc]);
      chk("busy", int'(burst_busy), int'(e_busy[cyc]));
      chk("cmd_err", int'(cmd_err), int'(e_err[cyc]));
      chk("dq_valid", int'(dq_valid), int'(e_v[cyc]));
      if (!e_v[cyc])
        chk("dqout_idle", int'(dqout), 0);
      else if (!e_dk[cyc])
        chk("dqout", int'(dqout), e_d[cyc]);
      if (e_rowchk[cyc])
        chk("open_row", int'(open_row), e_row[cyc]);
      if (dq_valid) begin
        if (rq.size() == 0) first_v = cyc;
        rq.push_back(int'(dqout));
      end
      if (cmd_err) err_cnt++;
    end
  end

  initial begin
    reset_n = 1'b0;
    cmd     = '0;
    row     = '0;
    column  = '0;
    dqin    = '0;
    err_cnt = 0;
    first_v = -1;
    model_reset();

    step(NOP, 0, 0, 1);
    chk("rst_state", int'(state), 0);
    chk("rst_row", int'(open_row), 0);
    chk("rst_valid", int'(dq_valid), 0);
    step(NOP, 0, 0, 1);
    step(NOP, 0, 0, 1);
    nop(2);

    step(ACT, 1);
    nop(TRCD - 1);
    wr_buf = '{3, 7, 1, 0, 9, 15, 2, 5};
    step(WR, 0, 0);
    nop(TCWL + BL);
    rq.delete();
    first_v = -1;
    rd_n = cyc + 1;
    step(RD, 0, 0);
    nop(TCL + BL);
    lit = '{3, 7, 1, 0, 9, 15, 2, 5};
    chk_burst("r38");
    chk("r38_lat", first_v - rd_n, 3);

    wr_buf = '{0, 1, 2, 3, 4, 5, 6, 7};
    step(WR, 0, 6);
    nop(TCWL + BL);
    rq.delete();
    step(RD, 0, 0);
    nop(TCL + BL);
    lit = '{2, 3, 4, 5, 6, 7, 0, 1};
    chk_burst("r39");

    step(3'd6);
    step(3'd7);

    step(PRE);
    nop(TRP - 1);
    step(ACT, 1);
    nop(TRCD - 2);
    err_cnt = 0;
    rq.delete();
    step(RD, 0, 8);
    step(RD, 0, 0);
    nop(2);
    step(RD, 0, 8);
    nop(TCL + BL);
    chk("r40_errs", err_cnt, 2);
    chk("r40_beats", rq.size(), 8);

    step(PRE);
    nop(TRP - 2);
    step(ACT, 2);
    chk("r41_err", int'(cmd_err), 1);
    step(ACT, 2);
    chk("r41_state", int'(state), 1);
    chk("r41_err2", int'(cmd_err), 0);

    nop(TRCD - 1);
    wr_buf = '{10, 11, 12, 13, 14, 15, 1, 2};
    step(WR, 0, 16);
    nop(TCWL + BL);
    step(PRE);
    nop(TRP - 1);
    step(ACT, 1);
    nop(TRCD - 1);
    wr_buf = '{5, 5, 5, 5, 5, 5, 5, 5};
    step(WR, 0, 16);
    nop(TCWL + BL);
    step(PRE);
    nop(TRP - 1);
    step(ACT, 2);
    nop(TRCD);
    chk("r43_row", int'(open_row), 2);
    rq.delete();
    step(RD, 0, 16);
    nop(TCL + BL);
    lit = '{10, 11, 12, 13, 14, 15, 1, 2};
    chk_burst("r43");

    wr_buf = '{9, 8, 7, 6, 5, 4, 3, 2};
    step(WR, 0, 16);
    nop(5);
    step(NOP, 0, 0, 1);
    chk("r42_busy", int'(burst_busy), 0);
    step(NOP, 0, 0, 1);
    step(NOP, 0, 0, 1);
    step(ACT, 2);
    nop(TRCD - 1);
    rq.delete();
    step(RD, 0, 16);
    nop(TCL + BL);
    lit = '{9, 8, 7, 13, 14, 15, 1, 2};
    chk_burst("r42");

    #10;
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
